// File: rtl/multi_ball_motion.sv
// multi_ball_motion: NUM_BALLS keyboard-steered balls with per-ball speed, selection and pause.
// Define MOTION_WRAP_EN to wrap balls to the opposite edge instead of bouncing.
module multi_ball_motion #(
  parameter int NUM_BALLS = 4,
  parameter int COORD_W = 10,
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int BALL_S = 16,
  parameter int STEP_MAX = 4
)(
  input  logic frame_clk,
  input  logic Reset,
  input  logic [7:0] keycode,
  output logic [NUM_BALLS*COORD_W-1:0] BallX,
  output logic [NUM_BALLS*COORD_W-1:0] BallY,
  output logic [COORD_W-1:0] BallS,
  output logic [(NUM_BALLS > 1 ? $clog2(NUM_BALLS) : 1)-1:0] Sel,
  output logic Paused
);
  localparam int SEL_W = NUM_BALLS > 1 ? $clog2(NUM_BALLS) : 1;
  localparam int SPD_W = $clog2(STEP_MAX + 1);
  localparam int CW2 = COORD_W + 2;
  localparam logic signed [CW2-1:0] XLO = CW2'(X_MIN + BALL_S);
  localparam logic signed [CW2-1:0] XHI = CW2'(X_MAX - BALL_S);
  localparam logic signed [CW2-1:0] YLO = CW2'(Y_MIN + BALL_S);
  localparam logic signed [CW2-1:0] YHI = CW2'(Y_MAX - BALL_S);
  localparam logic [7:0] K_W = 8'h1A, K_S = 8'h16, K_A = 8'h04, K_D = 8'h07;
  localparam logic [7:0] K_TAB = 8'h2B, K_SPACE = 8'h2C, K_INC = 8'h2E, K_DEC = 8'h2D;
  localparam logic RUN = 1'b0, PAUSED = 1'b1;

  // Returns {direction, position} after one frame of motion on one axis.
  function automatic logic [COORD_W+1:0] axis(input logic [COORD_W-1:0] p, input logic signed [1:0] d,
                                                input logic [SPD_W-1:0] s, input logic signed [CW2-1:0] lo,
                                                input logic signed [CW2-1:0] hi);
    logic signed [CW2-1:0] v, c;
    v = $signed({{(CW2-SPD_W){1'b0}}, s});
    c = $signed({2'b00, p}) + (d == 2'sb01 ? v : d == 2'sb11 ? -v : '0);
`ifdef MOTION_WRAP_EN
    axis = c > hi ? {d, lo[COORD_W-1:0]} : c < lo ? {d, hi[COORD_W-1:0]} : {d, c[COORD_W-1:0]};
`else
    axis = c > hi ? {2'b11, hi[COORD_W-1:0]} : c < lo ? {2'b01, lo[COORD_W-1:0]} : {d, c[COORD_W-1:0]};
`endif
  endfunction

  logic [7:0] prev_key;
  logic state, paused_n, tab_e, space_e, inc_e, dec_e, dir_key;
  logic signed [1:0] kdx, kdy;
  logic [SEL_W-1:0] sel;

  always_comb begin
    tab_e = keycode == K_TAB && prev_key != K_TAB;
    space_e = keycode == K_SPACE && prev_key != K_SPACE;
    inc_e = keycode == K_INC && prev_key != K_INC;
    dec_e = keycode == K_DEC && prev_key != K_DEC;
    dir_key = keycode inside {K_W, K_S, K_A, K_D};
    kdx = keycode == K_A ? 2'sb11 : keycode == K_D ? 2'sb01 : 2'sb00;
    kdy = keycode == K_W ? 2'sb11 : keycode == K_S ? 2'sb01 : 2'sb00;
    paused_n = state ^ space_e;
  end

  always_ff @(posedge frame_clk)
    if (Reset) begin
      prev_key <= '0;
      state <= RUN;
      sel <= '0;
    end else begin
      prev_key <= keycode;
      state <= paused_n;
      if (tab_e) sel <= sel == SEL_W'(NUM_BALLS - 1) ? '0 : sel + SEL_W'(1);
    end

  assign Sel = sel;
  assign Paused = state;
  assign BallS = COORD_W'(BALL_S);

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
    localparam int X0 = X_MIN + (i + 1) * (X_MAX - X_MIN + 1) / (NUM_BALLS + 1);
    localparam int Y0 = (Y_MIN + Y_MAX + 1) / 2;
    logic [COORD_W-1:0] px, py;
    logic signed [1:0] dx, dy, ex, ey;
    logic [SPD_W-1:0] spd, spd_n;
    logic [COORD_W+1:0] nx, ny;
    logic me;
    always_comb begin
      me = sel == SEL_W'(i);
      spd_n = !me || state == PAUSED ? spd :
              inc_e && spd < SPD_W'(STEP_MAX) ? spd + SPD_W'(1) :
              dec_e && spd > SPD_W'(1) ? spd - SPD_W'(1) : spd;
      ex = me && dir_key ? kdx : dx;
      ey = me && dir_key ? kdy : dy;
      nx = axis(px, ex, spd_n, XLO, XHI);
      ny = axis(py, ey, spd_n, YLO, YHI);
    end
    always_ff @(posedge frame_clk)
      if (Reset) begin
        px <= COORD_W'(X0);
        py <= COORD_W'(Y0);
        dx <= 2'sb01;
        dy <= 2'(i % 2);
        spd <= SPD_W'(1);
      end else if (!paused_n) begin
        {dx, px} <= nx;
        {dy, py} <= ny;
        spd <= spd_n;
      end
    assign BallX[i*COORD_W +: COORD_W] = px;
    assign BallY[i*COORD_W +: COORD_W] = py;
  end
endmodule

// File: tb/tb_multi_ball_motion.sv
// tb_multi_ball_motion: randomized and directed checks of multi_ball_motion against a frame-level model.
module tb_multi_ball_motion;
  localparam int N = 4, CW = 10, XMAX = 639, YMAX = 479, BS = 16, SMAX = 4;
  logic frame_clk = 1'b0, Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic [N*CW-1:0] BallX, BallY;
  logic [CW-1:0] BallS;
  logic [1:0] Sel;
  logic Paused;
  int errors = 0, checks = 0;
  int m_x[N], m_y[N], m_dx[N], m_dy[N], m_s[N], m_sel, m_p;
  logic [7:0] m_prev;

  multi_ball_motion dut (.frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .BallX(BallX),
                         .BallY(BallY), .BallS(BallS), .Sel(Sel), .Paused(Paused));

  always #5 frame_clk = ~frame_clk;

  function automatic int gx(input int i);
    return int'(BallX[i*CW +: CW]);
  endfunction
  function automatic int gy(input int i);
    return int'(BallY[i*CW +: CW]);
  endfunction

  task automatic move(input int p, d, s, lo, hi, output int np, nd);
    int c;
    c = p + d * s;
    np = c;
    nd = d;
    if (c + BS > hi) begin
`ifdef MOTION_WRAP_EN
      np = lo + BS;
`else
      np = hi - BS;
      nd = -1;
`endif
    end else if (c - BS < lo) begin
`ifdef MOTION_WRAP_EN
      np = hi - BS;
`else
      np = lo + BS;
      nd = 1;
`endif
    end
  endtask

  task automatic model_step(input logic [7:0] k, input logic r);
    bit edge_k, dk;
    int kx, ky, ex, ey;
    if (r) begin
      for (int b = 0; b < N; b++) begin
        m_x[b] = (b + 1) * (XMAX + 1) / (N + 1);
        m_y[b] = (YMAX + 1) / 2;
        m_dx[b] = 1;
        m_dy[b] = b % 2;
        m_s[b] = 1;
      end
      m_sel = 0;
      m_p = 0;
      m_prev = 8'h00;
      return;
    end
    edge_k = k != m_prev;
    dk = 1'b1;
    kx = 0;
    ky = 0;
    case (k)
      8'h1A: ky = -1;
      8'h16: ky = 1;
      8'h04: kx = -1;
      8'h07: kx = 1;
      default: dk = 1'b0;
    endcase
    if (k == 8'h2C && edge_k) m_p = 1 - m_p;
    if (m_p == 0)
      for (int b = 0; b < N; b++) begin
        if (b == m_sel && edge_k && k == 8'h2E && m_s[b] < SMAX) m_s[b]++;
        if (b == m_sel && edge_k && k == 8'h2D && m_s[b] > 1) m_s[b]--;
        ex = (b == m_sel && dk) ? kx : m_dx[b];
        ey = (b == m_sel && dk) ? ky : m_dy[b];
        move(m_x[b], ex, m_s[b], 0, XMAX, m_x[b], m_dx[b]);
        move(m_y[b], ey, m_s[b], 0, YMAX, m_y[b], m_dy[b]);
      end
    if (k == 8'h2B && edge_k) m_sel = (m_sel + 1) % N;
    m_prev = k;
  endtask

  task automatic frame(input logic [7:0] k, input logic r = 1'b0);
    @(negedge frame_clk);
    keycode = k;
    Reset = r;
    @(posedge frame_clk);
    model_step(k, r);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gx(i) !== 128 * (i + 1) || gy(i) !== 240) begin
        errors++;
        $display("FAIL %s ball%0d pos: got (%0d,%0d) expected (%0d,240)", tag, i, gx(i), gy(i), 128 * (i + 1));
      end
    end
    checks++;
    if (Sel !== 2'd0 || Paused !== 1'b0 || BallS !== 10'd16) begin
      errors++;
      $display("FAIL %s sel/paused/size: got %0d/%0b/%0d expected 0/0/16", tag, Sel, Paused, BallS);
    end
  endtask

  task automatic test_reset;
    frame(8'h00, 1'b1);
    check_reset_values("reset");
  endtask

  task automatic test_bounce;
    int ymax = 0;
    int e1, e2;
    frame(8'h00, 1'b1);
    repeat (495) begin
      frame(8'h00);
      if (gy(1) > ymax) ymax = gy(1);
    end
    checks++;
    if (gx(0) !== 623) begin errors++; $display("FAIL bounce_x495: got %0d expected 623", gx(0)); end
`ifdef MOTION_WRAP_EN
    e1 = 16; e2 = 17;
`else
    e1 = 623; e2 = 622;
`endif
    frame(8'h00);
    checks++;
    if (gx(0) !== e1) begin errors++; $display("FAIL bounce_x496: got %0d expected %0d", gx(0), e1); end
    frame(8'h00);
    checks++;
    if (gx(0) !== e2) begin errors++; $display("FAIL bounce_x497: got %0d expected %0d", gx(0), e2); end
    checks++;
    if (ymax !== 463) begin errors++; $display("FAIL bounce_ymax: got %0d expected 463", ymax); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gx(i) !== m_x[i] || gy(i) !== m_y[i]) begin
        errors++;
        $display("FAIL bounce_model ball%0d: got (%0d,%0d) expected (%0d,%0d)", i, gx(i), gy(i), m_x[i], m_y[i]);
      end
    end
  endtask

  task automatic test_tab;
    int exp_sel[4] = '{1, 2, 3, 0};
    frame(8'h00, 1'b1);
    repeat (10) frame(8'h2B);
    checks++;
    if (Sel !== 2'(exp_sel[0])) begin errors++; $display("FAIL tab_hold: got %0d expected 1", Sel); end
    for (int j = 1; j < 4; j++) begin
      frame(8'h00);
      frame(8'h2B);
      checks++;
      if (Sel !== 2'(exp_sel[j]) || int'(Sel) !== m_sel) begin
        errors++;
        $display("FAIL tab_press%0d: got %0d expected %0d", j, Sel, exp_sel[j]);
      end
    end
  endtask

  task automatic test_speed;
    int guard = 0, xmax = 0, e1, e2;
    frame(8'h00, 1'b1);
    repeat (3) frame(8'h00);
    repeat (5) begin
      frame(8'h2E);
      frame(8'h00);
    end
    checks++;
    if (gx(0) !== 165) begin errors++; $display("FAIL speed_sat: got %0d expected 165", gx(0)); end
    while (m_x[0] < 621 && guard < 200) begin
      frame(8'h00);
      guard++;
      if (gx(0) > xmax) xmax = gx(0);
    end
    checks++;
    if (gx(0) !== 621) begin errors++; $display("FAIL speed_x621: got %0d expected 621", gx(0)); end
`ifdef MOTION_WRAP_EN
    e1 = 16; e2 = 20;
`else
    e1 = 623; e2 = 619;
`endif
    frame(8'h00);
    if (gx(0) > xmax) xmax = gx(0);
    checks++;
    if (gx(0) !== e1) begin errors++; $display("FAIL speed_edge: got %0d expected %0d", gx(0), e1); end
    frame(8'h00);
    checks++;
    if (gx(0) !== e2) begin errors++; $display("FAIL speed_after: got %0d expected %0d", gx(0), e2); end
    checks++;
    if (xmax > 623) begin errors++; $display("FAIL speed_overshoot: got max %0d expected <= 623", xmax); end
  endtask

  task automatic test_pause;
    int sx[N], sy[N];
    bit bad;
    frame(8'h00, 1'b1);
    repeat (20) frame(8'h00);
    for (int i = 0; i < N; i++) begin sx[i] = m_x[i]; sy[i] = m_y[i]; end
    frame(8'h2C);
    checks++;
    if (Paused !== 1'b1) begin errors++; $display("FAIL pause_on: got %0b expected 1", Paused); end
    repeat (50) begin
      frame(8'h07);
      bad = 1'b0;
      for (int i = 0; i < N; i++) if (gx(i) !== sx[i] || gy(i) !== sy[i]) bad = 1'b1;
      checks++;
      if (bad) begin errors++; $display("FAIL pause_frozen: ball0 got (%0d,%0d) expected (%0d,%0d)", gx(0), gy(0), sx[0], sy[0]); end
    end
    frame(8'h2C);
    checks++;
    if (Paused !== 1'b0 || gx(0) !== sx[0] + 1 || gy(1) !== sy[1] + 1) begin
      errors++;
      $display("FAIL pause_resume: got paused=%0b x0=%0d y1=%0d expected 0/%0d/%0d", Paused, gx(0), gy(1), sx[0] + 1, sy[1] + 1);
    end
  endtask

  task automatic test_random;
    logic [7:0] pool[10] = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h2B, 8'h2C, 8'h2E, 8'h2D, 8'h11};
    logic [7:0] k = 8'h00;
    frame(8'h00, 1'b1);
    repeat (1500) begin
      if ($urandom_range(1) == 0) k = pool[$urandom_range(9)];
      frame(k);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (gx(i) !== m_x[i] || gy(i) !== m_y[i]) begin
          errors++;
          $display("FAIL random ball%0d key=%h: got (%0d,%0d) expected (%0d,%0d)", i, k, gx(i), gy(i), m_x[i], m_y[i]);
        end
      end
      checks++;
      if (int'(Sel) !== m_sel || int'(Paused) !== m_p) begin
        errors++;
        $display("FAIL random sel/paused key=%h: got %0d/%0b expected %0d/%0d", k, Sel, Paused, m_sel, m_p);
      end
    end
  endtask

  task automatic test_midreset;
    logic [7:0] pool[6] = '{8'h07, 8'h2B, 8'h2E, 8'h1A, 8'h2C, 8'h00};
    repeat (30) frame(pool[$urandom_range(5)]);
    frame(pool[$urandom_range(5)], 1'b1);
    check_reset_values("midreset");
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_tab();
    test_speed();
    test_pause();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
